trng_byte_arbiter: RTL and testbench
====================================

Name: trng_byte_arbiter

Overview:
- Shares the TRNG byte stream from the bit collector between NUM_REQ requesters using round-robin arbitration.
- Drives the collector enable and discards the first WARMUP_BYTES bytes after reset.
- Serves each granted request for a fixed number of bytes and flags a starved TRNG with a timeout.
- Sits between the bit collector and consumers such as key generators, nonce builders and the host interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LEN_W, 4, width of each per-requester byte-count field
- WARMUP_BYTES, 16, bytes discarded after reset before any grant
- TIMEOUT_CYC, 4096, max cycles between bytes in SERVE before abort

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester request level; held until done or abandoned
- req_len  in  NUM_REQ*LEN_W  requester i byte count at bits [i*LEN_W +: LEN_W]
- collector_enable  out  1  enable to the bit collector
- byte_ready  in  1  one-cycle pulse from the collector
- rand_byte  in  8  collected byte, valid with byte_ready
- grant  out  NUM_REQ  one-hot grant, all zero when not serving
- out_valid  out  1  byte delivered to the granted requester
- out_byte  out  8  delivered byte
- out_last  out  1  with out_valid: final byte of the request
- done  out  NUM_REQ  one-cycle pulse to the requester whose request completed
- timeout_err  out  1  one-cycle pulse when a request is aborted by timeout
- busy  out  1  high in WARMUP or SERVE

Behaviour:
- Single clock. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state=WARMUP, collector_enable=0, grant=0, out_valid=0, out_byte=0, out_last=0, done=0, timeout_err=0, busy=0, rr_ptr=NUM_REQ-1, counters=0.
- collector_enable=1 and busy=1 in WARMUP and SERVE, both starting the cycle after entry. Both are 0 in IDLE.
- WARMUP:
  - Every byte_ready increments warm_cnt; the byte is never forwarded.
  - On the WARMUP_BYTES-th byte, go to IDLE.
  - If WARMUP_BYTES=0, go to IDLE on the first cycle after reset.
  - No timeout in WARMUP.
- IDLE:
  - Eligible requesters: req[i]=1 and req_len[i]!=0. Zero-length requests are never granted.
  - Select the first eligible index searching from rr_ptr+1 upward with wrap-around.
  - Next cycle: grant=onehot(sel), len_rem=req_len[sel] latched, rr_ptr=sel, state=SERVE.
  - Arbitration latency is 1 cycle from req to grant.
  - A byte_ready arriving in IDLE (straggler after enable drops) is discarded.
- SERVE:
  - Each byte_ready gives, next cycle, out_valid=1, out_byte=rand_byte, len_rem decremented.
  - When len_rem==1, also out_last=1 and done[sel]=1 in that same cycle; grant clears and state=IDLE.
  - Back-to-back byte_ready pulses are all delivered; no byte is dropped or duplicated while granted.
- Abort, requester drops req:
  - Granted req[sel]=0 in SERVE: next cycle grant=0, state=IDLE, no done.
  - If byte_ready coincides with the drop, that byte is discarded.
- Timeout:
  - to_cnt clears on entry to SERVE and on each byte_ready, and increments otherwise.
  - When to_cnt reaches TIMEOUT_CYC-1 with no byte: timeout_err=1 for one cycle, grant=0, state=IDLE, no done.
  - rr_ptr stays at sel, so the aborted requester goes last in the next arbitration.
- Simultaneous events in SERVE: final byte beats a coincident timeout, so done is given and no error. A req drop beats a byte.
- Mid-operation reset returns to WARMUP and redoes the warm-up. Any partial request is lost with no done.
- Request changes:
  - A req_len change after grant is ignored.
  - A requester may re-request immediately after done. It competes in the next IDLE cycle with round-robin priority.

Decomposition:
- Package trng_pkg:
  - typedef arb_state_t {WARMUP, IDLE, SERVE}
  - function rr_next(req_mask, ptr) returning the selected index and a found flag
- Sub-module rr_arbiter (combinational round-robin picker, NUM_REQ wide) is natural and reusable. All sequencing stays in trng_byte_arbiter.

Test Plan:
- Warm-up: rst, then 16 byte_ready pulses with req[0]=1, len=2 -> no grant/out_valid until the 16th byte is consumed. grant=0001 follows, then 2 bytes delivered with out_last on the 2nd and done[0] pulse.
- Round-robin: after warm-up, req=1111, all len=1 -> grants in order 0,1,2,3,0 and one done per grant. Delivered out_byte values equal the driven rand_byte sequence A5,3C,F0,0F,81.
- Zero length and back-to-back: req=0011, req_len[0]=0, req_len[1]=3 -> requester 0 never granted. Requester 1 receives 3 consecutive-cycle bytes with no gaps or drops.
- Abort: grant to requester 2 with len=5, drop req[2] after 2 bytes -> grant clears next cycle, no done[2]. The next byte is not delivered and requester 3 is served.
- Timeout: TIMEOUT_CYC=32, grant with no byte_ready -> timeout_err pulses exactly 32 cycles after the grant cycle and grant=0. A final byte coinciding with the timeout cycle gives done with no error.
- Reset mid-SERVE: assert rst during a len=8 request after 3 bytes -> all outputs return to reset values and busy reasserts. Warm-up repeats fully before any new grant.

Source files
------------

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types and the round-robin search helper for the TRNG byte arbiter
package trng_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {WARMUP, IDLE, SERVE} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_sel_t;

  // First set bit of req_mask searching upward from ptr+1, wrapping at n.
  function automatic rr_sel_t rr_next(input logic [MAX_REQ-1:0] req_mask,
                                      input logic [2:0] ptr, input int n);
    rr_sel_t r;
    int      j;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !r.found && req_mask[3'(j)]) begin
        r.found = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker over N request lines
module rr_arbiter
  import trng_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_mask,
  input  logic [2:0]   ptr,
  output logic         found,
  output logic [2:0]   idx
);

  logic [MAX_REQ-1:0] mask_full;
  rr_sel_t            pick;

  always_comb begin
    mask_full         = '0;
    mask_full[N-1:0]  = req_mask;
    pick              = rr_next(mask_full, ptr, N);
  end

  assign found = pick.found;
  assign idx   = pick.idx;

endmodule

// File: rtl/trng_byte_arbiter.sv
// rtl/trng_byte_arbiter.sv - round-robin sharing of the TRNG byte stream with warm-up discard and timeout
module trng_byte_arbiter
  import trng_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LEN_W        = 4,
  parameter int WARMUP_BYTES = 16,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic                     collector_enable,
  input  logic                     byte_ready,
  input  logic [7:0]               rand_byte,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     out_valid,
  output logic [7:0]               out_byte,
  output logic                     out_last,
  output logic [NUM_REQ-1:0]       done,
  output logic                     timeout_err,
  output logic                     busy
);

  localparam int WC_W = $clog2(WARMUP_BYTES + 2);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] RR_RST = 3'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [WC_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [LEN_W-1:0]   len_rem_q, len_rem_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_last_q, out_last_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               timeout_err_q, timeout_err_d;
  logic               active_q, active_d;

  logic [NUM_REQ-1:0] elig;
  logic               arb_found;
  logic [2:0]         arb_idx;
  logic [LEN_W-1:0]   len_pick;
  logic [MAX_REQ-1:0] req_full;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_mask (elig),
    .ptr      (rr_ptr_q),
    .found    (arb_found),
    .idx      (arb_idx)
  );

  always_comb begin
    state_d       = state_q;
    warm_cnt_d    = warm_cnt_q;
    to_cnt_d      = to_cnt_q;
    len_rem_d     = len_rem_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    out_byte_d    = out_byte_q;
    out_valid_d   = 1'b0;
    out_last_d    = 1'b0;
    done_d        = '0;
    timeout_err_d = 1'b0;
    len_pick      = '0;
    req_full      = '0;
    req_full[NUM_REQ-1:0] = req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == arb_idx) len_pick = req_len[i*LEN_W +: LEN_W];
    end

    case (state_q)
      WARMUP: begin
        if (byte_ready) warm_cnt_d = warm_cnt_q + WC_W'(1);
        if (WARMUP_BYTES == 0 ||
            (byte_ready && warm_cnt_q == WC_W'(WARMUP_BYTES - 1))) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // Stragglers from the collector are dropped here by simply ignoring byte_ready.
        if (arb_found) begin
          state_d   = SERVE;
          sel_d     = arb_idx;
          rr_ptr_d  = arb_idx;
          len_rem_d = len_pick;
          to_cnt_d  = '0;
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (3'(i) == arb_idx);
        end
      end
      SERVE: begin
        // Priority: requester drop, then byte delivery, then timeout.
        if (!req_full[sel_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (byte_ready) begin
          out_valid_d = 1'b1;
          out_byte_d  = rand_byte;
          len_rem_d   = len_rem_q - LEN_W'(1);
          to_cnt_d    = '0;
          if (len_rem_q == LEN_W'(1)) begin
            out_last_d = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) done_d[i] = (3'(i) == sel_q);
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          timeout_err_d = 1'b1;
          grant_d       = '0;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WARMUP;
      warm_cnt_q    <= '0;
      to_cnt_q      <= '0;
      len_rem_q     <= '0;
      sel_q         <= '0;
      rr_ptr_q      <= RR_RST;
      grant_q       <= '0;
      out_valid_q   <= 1'b0;
      out_byte_q    <= '0;
      out_last_q    <= 1'b0;
      done_q        <= '0;
      timeout_err_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      warm_cnt_q    <= warm_cnt_d;
      to_cnt_q      <= to_cnt_d;
      len_rem_q     <= len_rem_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      out_valid_q   <= out_valid_d;
      out_byte_q    <= out_byte_d;
      out_last_q    <= out_last_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      active_q      <= active_d;
    end
  end

  assign collector_enable = active_q;
  assign busy             = active_q;
  assign grant            = grant_q;
  assign out_valid        = out_valid_q;
  assign out_byte         = out_byte_q;
  assign out_last         = out_last_q;
  assign done             = done_q;
  assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_trng_byte_arbiter.sv
// tb/tb_trng_byte_arbiter.sv - directed self-checking bench with a behavioural reference for trng_byte_arbiter
module tb_trng_byte_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int WB = 16;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic            byte_ready = 1'b0;
  logic [7:0]      rand_byte = '0;
  logic            collector_enable, out_valid, out_last, timeout_err, busy;
  logic [N-1:0]    grant, done;
  logic [7:0]      out_byte;

  always #5 clk = ~clk;

  trng_byte_arbiter #(.NUM_REQ(N), .LEN_W(LW), .WARMUP_BYTES(WB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len),
    .collector_enable(collector_enable), .byte_ready(byte_ready), .rand_byte(rand_byte),
    .grant(grant), .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
    .done(done), .timeout_err(timeout_err), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: phase 0 = discarding warm-up bytes, 1 = waiting for a request, 2 = serving.
  int         m_phase, m_warm_left, m_owner, m_left, m_wait, m_last, m_c;
  bit         model_on = 1'b0;
  logic [N-1:0] e_grant, e_done;
  logic       e_valid, e_last, e_to, e_busy;
  logic [7:0] e_byte;

  function automatic int len_of(input int i);
    return int'(req_len[i*LW +: LW]);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase = 0; m_warm_left = WB; m_last = N - 1; m_owner = 0; m_left = 0; m_wait = 0;
      e_grant = '0; e_done = '0; e_valid = 0; e_last = 0; e_to = 0; e_busy = 0; e_byte = '0;
      model_on = 1'b1;
    end else begin
      e_valid = 0; e_last = 0; e_done = '0; e_to = 0;
      if (m_phase == 0) begin
        if (byte_ready) m_warm_left--;
        if (m_warm_left <= 0) m_phase = 1;
      end else if (m_phase == 1) begin
        for (int k = 1; k <= N; k++) begin
          m_c = (m_last + k) % N;
          if (m_phase == 1 && req[m_c] && len_of(m_c) != 0) begin
            m_owner = m_c; m_left = len_of(m_c); m_wait = 0; m_last = m_c; m_phase = 2;
          end
        end
      end else begin
        if (!req[m_owner]) m_phase = 1;
        else if (byte_ready) begin
          e_valid = 1; e_byte = rand_byte; m_left--; m_wait = 0;
          if (m_left == 0) begin
            e_last = 1; e_done = N'(1 << m_owner); m_phase = 1;
          end
        end else if (m_wait == TO - 1) begin
          e_to = 1; m_phase = 1;
        end else m_wait++;
      end
      e_grant = (m_phase == 2) ? N'(1 << m_owner) : '0;
      e_busy  = (m_phase != 1);
    end
  end

  logic [7:0]   got_q[$];
  int           grant_log[$];
  int           done_cnt[N];
  int           to_seen = 0;
  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin
    if (model_on) begin
      chk("grant", grant, e_grant);
      chk("out_valid", out_valid, e_valid);
      if (e_valid) chk("out_byte", out_byte, e_byte);
      chk("out_last", out_last, e_last);
      chk("done", done, e_done);
      chk("timeout_err", timeout_err, e_to);
      chk("busy", busy, e_busy);
      chk("collector_enable", collector_enable, e_busy);
      if (out_valid) got_q.push_back(out_byte);
      if (grant != 0 && prev_grant == 0)
        for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
      prev_grant = grant;
      for (int i = 0; i < N; i++) done_cnt[i] += int'(done[i]);
      to_seen += int'(timeout_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_ready = 1'b1;
    rand_byte  = b;
    tick();
    byte_ready = 1'b0;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (grant == 0 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_grant", 32'(grant != 0), 1);
  endtask

  task automatic reset_warm();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < WB; i++) send_byte(8'(8'hE0 + i));
    tick();
  endtask

  logic [7:0] rr_bytes[5] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81};
  int         rr_order[5] = '{0, 1, 2, 3, 0};
  int         gb, lb, dsnap, tsnap, g;

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", collector_enable, 0);
    chk("rst_out_byte", out_byte, 0);

    // Warm-up discard then a 2-byte request
    req = 4'b0001; req_len = 16'h0002;
    for (int i = 0; i < WB; i++) send_byte(8'(i + 1));
    chk("warm_no_grant", grant_log.size(), 0);
    chk("warm_no_data", got_q.size(), 0);
    chk("warm_grant_after16", grant, 0);
    wait_grant();
    chk("s1_grant", grant, 4'b0001);
    send_byte(8'h11);
    send_byte(8'h22);
    req = '0;
    chk("s1_last", out_last, 1);
    chk("s1_done", done, 4'b0001);
    tick();
    chk("s1_count", got_q.size(), 2);
    chk("s1_b0", got_q[0], 8'h11);
    chk("s1_b1", got_q[1], 8'h22);

    // Round robin across four len=1 requesters
    reset_warm();
    gb = grant_log.size(); lb = got_q.size();
    req = 4'b1111; req_len = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      send_byte(rr_bytes[k]);
    end
    req = '0;
    tick();
    chk("rr_grants", grant_log.size() - gb, 5);
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", grant_log[gb + k], rr_order[k]);
      chk("rr_byte", got_q[lb + k], rr_bytes[k]);
    end

    // Zero length never granted; back-to-back delivery
    gb = grant_log.size(); lb = got_q.size();
    req = 4'b0011; req_len = 16'h0030;
    wait_grant();
    chk("zl_grant", grant, 4'b0010);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    req = '0;
    chk("zl_done", done, 4'b0010);
    tick(); tick();
    chk("zl_single_grant", grant_log.size() - gb, 1);
    chk("zl_b0", got_q[lb], 8'hC1);
    chk("zl_b2", got_q[lb + 2], 8'hC3);
    chk("zl_cnt", got_q.size() - lb, 3);

    // Abort by dropping req with a coincident byte
    lb = got_q.size(); dsnap = done_cnt[2];
    req = 4'b1100; req_len = 16'h1500;
    wait_grant();
    chk("ab_grant", grant, 4'b0100);
    send_byte(8'h31); send_byte(8'h32);
    req = 4'b1000; byte_ready = 1'b1; rand_byte = 8'h33;
    tick();
    byte_ready = 1'b0;
    chk("ab_grant_clear", grant, 0);
    chk("ab_no_valid", out_valid, 0);
    wait_grant();
    chk("ab_next_grant", grant, 4'b1000);
    send_byte(8'h44);
    req = '0;
    tick();
    chk("ab_no_done2", done_cnt[2], dsnap);
    chk("ab_cnt", got_q.size() - lb, 3);
    chk("ab_b2", got_q[lb + 2], 8'h44);

    // Timeout exactly TO cycles after the grant cycle
    tsnap = to_seen; dsnap = done_cnt[0];
    req = 4'b0001; req_len = 16'h0001;
    wait_grant();
    g = cyc;
    for (int n = 0; n < 60 && !timeout_err; n++) tick();
    req = '0;
    chk("to_latency", cyc - g, TO);
    chk("to_pulse", timeout_err, 1);
    chk("to_grant", grant, 0);
    tick();
    chk("to_one_cycle", timeout_err, 0);
    chk("to_no_done", done_cnt[0], dsnap);

    // Final byte on the timeout cycle wins
    req = 4'b0001;
    wait_grant();
    repeat (TO - 1) tick();
    send_byte(8'h5A);
    req = '0;
    chk("tc_done", done, 4'b0001);
    chk("tc_no_err", timeout_err, 0);
    chk("tc_byte", out_byte, 8'h5A);
    tick(); tick();
    chk("tc_to_total", to_seen - tsnap, 1);

    // Reset in the middle of a len=8 request
    dsnap = done_cnt[1];
    req = 4'b0010; req_len = 16'h0080;
    wait_grant();
    send_byte(8'h71); send_byte(8'h72); send_byte(8'h73);
    rst = 1'b1;
    tick();
    chk("mr_grant", grant, 0);
    chk("mr_busy", busy, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_done", done, 0);
    rst = 1'b0;
    tick();
    chk("mr_busy_again", busy, 1);
    for (int i = 0; i < WB - 1; i++) send_byte(8'(8'h90 + i));
    tick(); tick();
    chk("mr_still_warming", grant, 0);
    send_byte(8'h9F);
    wait_grant();
    chk("mr_regrant", grant, 4'b0010);
    chk("mr_no_done", done_cnt[1], dsnap);
    req = '0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
